block_window_reader: RTL and testbench
======================================

Name: block_window_reader

Overview:
- Parametrised successor to the fixed 8-pixel, 24-bit block reader in the stereoscopic comparator IP.
- Pulls one run of up to MAX_BLOCK_SIZE pixels from an AXI4-Stream video input into a parallel shift-register window.
- The window length is chosen at run time. Start-of-frame beats resynchronise the window, and end-of-line/start-of-frame status is reported alongside the block.
- Sits between the AXIS video input and the block comparator; the comparator issues go and consumes block when done is high.

Parameters:
- DATA_WIDTH, 24, bits per pixel beat.
- MAX_BLOCK_SIZE, 8, maximum pixels per block (>=2).
- COUNT_W, $clog2(MAX_BLOCK_SIZE+1), width of count and block_len.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  pixel data.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&&tready.
- go  in  1  start capture of the next block.
- block_len  in  COUNT_W  requested pixels; sampled only on go.
- done  out  1  block complete; level held until next go.
- block  out  MAX_BLOCK_SIZE*DATA_WIDTH  window; newest pixel in bits [DATA_WIDTH-1:0].
- count  out  COUNT_W  pixels captured in current block.
- eol  out  1  block was terminated by tlast.
- sof  out  1  block contains a tuser beat.

Behaviour:
- Reset (async assert, sync release): state=IDLE; s_axis_tready=0, done=0, block=0, count=0, eol=0, sof=0, latched length=MAX_BLOCK_SIZE.
- States: IDLE, ACCEPT, PAD (exists only with ZERO_PAD_EN), DONE.
- IDLE/DONE + go:
  - next state is ACCEPT; count, eol, sof and done are cleared on that edge; block is kept.
  - block_len is latched. A value of 0 or greater than MAX_BLOCK_SIZE latches as MAX_BLOCK_SIZE.
- s_axis_tready = (state==ACCEPT), decoded combinationally from the state register.
  - There is no bubble: one beat can be accepted every cycle.
  - tready is never high in IDLE, PAD or DONE.
- Accepted beat in ACCEPT:
  - block <= {block[MAX-1 slots], tdata}; count <= count+1.
  - If tuser=1 and count!=0: resync. block <= {zeros, tdata}, count <= 1, sof <= 1, eol <= 0.
  - If tuser=1 and count==0: sof <= 1, normal shift.
- Termination on an accepted beat, evaluated after any resync:
  - new count == latched length, or tlast=1.
  - eol <= tlast. Next state is DONE, or PAD if ZERO_PAD_EN and new count < latched length.
  - A beat with both tlast and count==length gives eol=1 and DONE.
- done = (state==DONE), registered; first high one cycle after the terminating beat.
  - Latency from go to the first possible accept: 1 cycle.
- go while in ACCEPT or PAD is ignored.
- go in DONE with tvalid already high: the beat is accepted the cycle after go.
- tvalid low in ACCEPT: hold all state; no timeout.
- Reset mid-block: immediate return to reset values; the partial block is discarded.

Optional Feature:
- Macro: BLOCK_WINDOW_READER_ZERO_PAD_EN.
- Enabled:
  - PAD state shifts in zero pixels, one per cycle, incrementing count until count == latched length, then goes to DONE.
  - The first pixel of the line always ends in slot length-1.
  - PAD lasts length-count cycles; tready is 0 throughout.
- Disabled:
  - An early tlast goes straight to DONE with count < length.
  - Valid pixels occupy slots [count-1:0]; the consumer must use count.

Decomposition:
- Package comperator_pkg holds:
  - DEFAULT_DATA_WIDTH=24 and DEFAULT_BLOCK_SIZE=8.
  - State enum typedef block_reader_state_t {IDLE, ACCEPT, PAD, DONE}, 2-bit.
  - Function clamp_len().
- One sub-module: block_shift_window. Parametrised shift register with shift, clear-and-load and zero-shift controls; the FSM stays in the top.

Test Plan:
1. MAX=8, block_len=8, go, 8 back-to-back beats 0x000001..0x000008 with tlast on beat 8.
   - count=8, eol=1, done one cycle after beat 8, block LSB=0x000008, MSB slot=0x000001.
2. block_len=3, tvalid toggled 1,0,1,0,1.
   - Exactly 3 accepts, done after the 3rd, count=3.
   - tready drops to 0 in DONE while tvalid is still high.
3. block_len=8, tlast on beat 5.
   - Without the macro: done, count=5, eol=1, slot4=first pixel.
   - With the macro: 3 PAD cycles, count=8, slots[2:0]=0, slot7=first pixel, then done.
4. block_len=6, tuser asserted on beat 3 (data 0xAA).
   - count restarts at 1; sof=1; block=0xAA followed by the next 5 beats.
   - done after 6 beats counted from the tuser beat.
5. block_len=0 and block_len=12 with MAX=8: each captures 8 beats.
   - go held high in ACCEPT has no effect.
6. aresetn pulsed low mid-block (after 4 beats, between clock edges).
   - Outputs go to reset values immediately, before the next clock.
   - The next go starts again from count=0.

Source files
------------

// File: rtl/comperator_pkg.sv
// Shared types and helpers for the stereoscopic comparator block readers.
// Holds default geometry, the block reader state encoding and the length clamp.
package comperator_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_BLOCK_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    PAD    = 2'd2,
    DONE   = 2'd3
  } block_reader_state_t;

  // A zero or oversized request means "a full window".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0 || len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/block_shift_window.sv
// Parallel-output pixel shift register; newest pixel lives in the low slot.
// Load clears the window and inserts one pixel; zero shift inserts a blank pixel.
module block_shift_window #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        shift_en,
  input  logic                        load_en,
  input  logic                        zero_en,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DEPTH*DATA_WIDTH-1:0] window
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      window <= '0;
    end else if (load_en) begin
      window <= (DEPTH*DATA_WIDTH)'(din);
    end else if (shift_en) begin
      window <= {window[(DEPTH-1)*DATA_WIDTH-1:0], din};
    end else if (zero_en) begin
      window <= {window[(DEPTH-1)*DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
    end
  end

endmodule

// File: rtl/block_window_reader.sv
// Captures a run of up to MAX_BLOCK_SIZE AXIS video pixels into a shift window.
// Optional zero padding of short lines: define BLOCK_WINDOW_READER_ZERO_PAD_EN.
module block_window_reader
  import comperator_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int MAX_BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
  parameter int COUNT_W        = $clog2(MAX_BLOCK_SIZE + 1)
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tlast,
  input  logic                                 s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 go,
  input  logic [COUNT_W-1:0]                   block_len,
  output logic                                 done,
  output logic [MAX_BLOCK_SIZE*DATA_WIDTH-1:0] block,
  output logic [COUNT_W-1:0]                   count,
  output logic                                 eol,
  output logic                                 sof
);

  block_reader_state_t state, state_next;
  logic [COUNT_W-1:0]  len_q;
  logic [COUNT_W-1:0]  new_count;
  logic                beat, resync, term, start, pad_step;

  assign beat      = s_axis_tvalid && s_axis_tready;
  assign resync    = beat && s_axis_tuser && (count != '0);
  assign new_count = resync ? COUNT_W'(1) : count + COUNT_W'(1);
  assign term      = beat && ((new_count == len_q) || s_axis_tlast);
  assign start     = go && ((state == IDLE) || (state == DONE));
`ifdef BLOCK_WINDOW_READER_ZERO_PAD_EN
  assign pad_step  = (state == PAD);
`else
  assign pad_step  = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (go) state_next = ACCEPT;
      ACCEPT: begin
        if (term) begin
`ifdef BLOCK_WINDOW_READER_ZERO_PAD_EN
          state_next = (new_count < len_q) ? PAD : DONE;
`else
          state_next = DONE;
`endif
        end
      end
      PAD: begin
`ifdef BLOCK_WINDOW_READER_ZERO_PAD_EN
        if (count + COUNT_W'(1) == len_q) state_next = DONE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = (state == ACCEPT);
    done          = (state == DONE);
  end

  // Length, count and status flags; the window itself keeps its contents across go.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
      eol   <= 1'b0;
      sof   <= 1'b0;
      len_q <= COUNT_W'(MAX_BLOCK_SIZE);
    end else if (start) begin
      count <= '0;
      eol   <= 1'b0;
      sof   <= 1'b0;
      len_q <= COUNT_W'(clamp_len(32'(block_len), 32'(MAX_BLOCK_SIZE)));
    end else if (beat) begin
      count <= new_count;
      if (s_axis_tuser) sof <= 1'b1;
      if (term)         eol <= s_axis_tlast;
      else if (resync)  eol <= 1'b0;
    end else if (pad_step) begin
      count <= count + COUNT_W'(1);
    end
  end

  block_shift_window #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_BLOCK_SIZE)
  ) u_window (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .shift_en (beat && !resync),
    .load_en  (resync),
    .zero_en  (pad_step),
    .din      (s_axis_tdata),
    .window   (block)
  );

endmodule

// File: tb/tb_block_window_reader.sv
// Directed plus randomized bench for block_window_reader against a queue-based model.
// Build with BLOCK_WINDOW_READER_ZERO_PAD_EN defined to check the padding variant.
module tb_block_window_reader;

  localparam int DW  = 24;
  localparam int MAX = 8;
  localparam int CW  = 4;
  localparam int BW  = MAX * DW;
`ifdef BLOCK_WINDOW_READER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast, s_axis_tuser, s_axis_tvalid, s_axis_tready;
  logic          go;
  logic [CW-1:0] block_len;
  logic          done, eol, sof;
  logic [BW-1:0] block;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 capturing, 2 padding, 3 complete.
  int            m_phase, m_cnt, m_len;
  bit            m_eol, m_sof;
  logic [DW-1:0] m_win[$];

  block_window_reader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .go            (go),
    .block_len     (block_len),
    .done          (done),
    .block         (block),
    .count         (count),
    .eol           (eol),
    .sof           (sof)
  );

  always #5 aclk = ~aclk;

  task automatic modelReset();
    m_phase = 0;
    m_cnt   = 0;
    m_len   = MAX;
    m_eol   = 0;
    m_sof   = 0;
    m_win.delete();
  endtask

  task automatic modelPush(input logic [DW-1:0] px);
    m_win.push_back(px);
    if (m_win.size() > MAX) void'(m_win.pop_front());
  endtask

  function automatic logic [BW-1:0] expectedBlock();
    logic [BW-1:0] blk = '0;
    for (int i = 0; i < MAX; i++)
      if (i < m_win.size()) blk[i*DW +: DW] = m_win[m_win.size()-1-i];
    return blk;
  endfunction

  task automatic checkValue(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("tready", BW'(s_axis_tready), BW'(m_phase == 1));
    checkValue("done",   BW'(done),          BW'(m_phase == 3));
    checkValue("count",  BW'(count),         BW'(m_cnt));
    checkValue("eol",    BW'(eol),           BW'(m_eol));
    checkValue("sof",    BW'(sof),           BW'(m_sof));
    checkValue("block",  block,              expectedBlock());
  endtask

  // One clock: check current outputs, drive inputs, advance the model, move to next negedge.
  task automatic applyStimulus(input logic g, input logic [CW-1:0] bl, input logic v,
                               input logic [DW-1:0] d, input logic l, input logic u);
    checkOutput();
    go = g; block_len = bl; s_axis_tvalid = v; s_axis_tdata = d;
    s_axis_tlast = l; s_axis_tuser = u;
    case (m_phase)
      0, 3: if (g) begin
        m_phase = 1; m_cnt = 0; m_eol = 0; m_sof = 0;
        m_len = (bl == 0 || int'(bl) > MAX) ? MAX : int'(bl);
      end
      1: if (v) begin
        if (u && m_cnt != 0) begin
          m_win.delete();
          m_cnt = 0;
        end
        modelPush(d);
        m_cnt++;
        if (u) m_sof = 1;
        if (m_cnt == m_len || l) begin
          m_eol   = l;
          m_phase = (PAD_EN && m_cnt < m_len) ? 2 : 3;
        end
      end
      2: begin
        modelPush('0);
        m_cnt++;
        if (m_cnt == m_len) m_phase = 3;
      end
      default: m_phase = 0;
    endcase
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] first_px;
    aresetn = 1'b0;
    go = 0; block_len = '0; s_axis_tvalid = 0; s_axis_tdata = '0;
    s_axis_tlast = 0; s_axis_tuser = 0;
    modelReset();
    @(negedge aclk);
    checkOutput();
    aresetn = 1'b1;

    // Full 8-pixel line, tlast coincides with the length.
    applyStimulus(1'b1, CW'(8), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, '0, 1'b1, DW'(i), i == 8, 1'b0);
    checkValue("t1_lsb", BW'(block[DW-1:0]), BW'(24'h000008));
    checkValue("t1_msb", BW'(block[BW-1 -: DW]), BW'(24'h000001));
    checkValue("t1_done", BW'(done), BW'(1'b1));
    idleCycles(1);

    // Length 3 with a gappy tvalid; tvalid stays high into DONE.
    applyStimulus(1'b1, CW'(3), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, (i % 2) == 0, DW'($urandom), 1'b0, 1'b0);
    checkValue("t2_count", BW'(count), BW'(3));
    applyStimulus(1'b0, '0, 1'b1, DW'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, DW'($urandom), 1'b0, 1'b0);

    // Early tlast on beat 5 of an 8-pixel request.
    applyStimulus(1'b1, CW'(8), 1'b0, '0, 1'b0, 1'b0);
    first_px = DW'($urandom);
    applyStimulus(1'b0, '0, 1'b1, first_px, 1'b0, 1'b0);
    for (int i = 2; i <= 5; i++) applyStimulus(1'b0, '0, 1'b1, DW'($urandom), i == 5, 1'b0);
    idleCycles(4);
    checkValue("t3_first_slot", BW'(block[(PAD_EN ? 7 : 4)*DW +: DW]), BW'(first_px));
    checkValue("t3_count", BW'(count), BW'(PAD_EN ? 8 : 5));

    // Start-of-frame on beat 3 resynchronises the window.
    applyStimulus(1'b1, CW'(6), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b0, '0, 1'b1, (i == 3) ? DW'(24'hAA) : DW'($urandom), 1'b0, i == 3);
    checkValue("t4_oldest", BW'(block[5*DW +: DW]), BW'(24'hAA));
    checkValue("t4_sof", BW'(sof), BW'(1'b1));
    idleCycles(1);

    // Clamped lengths; go held high during capture.
    applyStimulus(1'b1, CW'(0), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, CW'(3), 1'b1, DW'($urandom), 1'b0, 1'b0);
    checkValue("t5_len0", BW'(count), BW'(8));
    applyStimulus(1'b1, CW'(12), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, CW'(2), 1'b1, DW'($urandom), 1'b0, 1'b0);
    checkValue("t5_len12", BW'(count), BW'(8));
    idleCycles(1);

    // Asynchronous reset between edges after 4 beats.
    applyStimulus(1'b1, CW'(8), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, DW'($urandom), 1'b0, 1'b0);
    #2 aresetn = 1'b0;
    #1 modelReset();
    checkOutput();
    @(negedge aclk);
    aresetn = 1'b1;
    applyStimulus(1'b1, CW'(4), 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, DW'($urandom), 1'b0, 1'b0);
    checkValue("t6_restart", BW'(count), BW'(1));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, DW'($urandom), 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1'b1, CW'($urandom_range(0, 15)), 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
        applyStimulus($urandom_range(0, 5) == 0, CW'($urandom_range(0, 15)),
                      $urandom_range(0, 1) == 1, DW'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
